dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the pipeline MEM stage (port 0) and the debug/loader port (port 1). Port 0 has fixed priority, with a starvation counter that guarantees port 1 service. The arbiter also enforces the ROM write-protect and address-range rules at the request side. Read data is registered and returned with a valid strobe. It sits between the MEM stage / debug bridge and the data memory instance.

## Interface

- `MEM_SIZE`, 256: number of 64-bit words; must match the memory instance.
- `ROM_SIZE`, 2: words `[0, ROM_SIZE-1]` are read-only.
- `STARVE_LIMIT`, 4: consecutive denied cycles after which port 1 is promoted; range 1..255.

Ports:

- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `p0_req`, `p1_req`  in  1  request; held with its payload until `pN_gnt`.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  32  word address.
- `p0_wdata`, `p1_wdata`  in  64  write data.
- `p0_gnt`, `p1_gnt`  out  1  request accepted this cycle (combinational).
- `p0_rvalid`, `p1_rvalid`  out  1  read data valid; one-cycle pulse.
- `p0_rdata`, `p1_rdata`  out  64  registered read data.
- `p0_err`, `p1_err`  out  1  one-cycle pulse when the accepted request was illegal.
- `mem_addr`  out  32  to memory.
- `mem_wr_data`  out  64  to memory.
- `mem_wr_enable`  out  1  to memory.
- `mem_rd_enable`  out  1  to memory.
- `mem_rd_data`  in  64  combinational read data from memory.

## Operation

- **Arbitration states:**
  - FAVOR0 (reset state): port 0 wins when both request.
  - FAVOR1: port 1 wins when both request.
- **Starvation counter `starve` (8 bit):**
  - Increments each cycle `p1_req & ~p1_gnt`, saturating at `STARVE_LIMIT`.
  - Cleared on `p1_gnt` or when `p1_req` = 0.
- **State transitions:**
  - FAVOR0 -> FAVOR1 when `starve` reaches `STARVE_LIMIT`. The counter value is registered, so FAVOR1 takes effect on the following cycle.
  - FAVOR1 -> FAVOR0 on `p1_gnt`.
  - FAVOR1 with `p1_req` = 0 -> FAVOR0.
- **Grant:**
  - At most one of `p0_gnt` / `p1_gnt` is high per cycle.
  - A lone requester is always granted.
  - No request means no grant, and all `mem_*` enables stay 0.
- **Granted request drives the memory:**
  - `mem_addr` = address.
  - `mem_wr_data` = wdata.
  - `mem_wr_enable` = we & legal.
  - `mem_rd_enable` = ~we & legal.
  - With no grant, `mem_addr` and `mem_wr_data` are 0.
- **Legality:**
  - Illegal: `addr >= MEM_SIZE` (any op), or a write with `addr < ROM_SIZE`.
  - An illegal request is still granted but issues no memory enable.
  - The following cycle it pulses `pN_err`; an illegal read also pulses `pN_rvalid` with `pN_rdata` = 0.
- **Read return:**
  - On a granted legal read, `mem_rd_data` is sampled into `pN_rdata` at the granting edge.
  - `pN_rvalid` = 1 for exactly the next cycle.
  - `pN_rdata` holds its value until the next read return on that port.
- **Writes:** produce no rvalid.
- **No outstanding limit:** back-to-back grants to the same port are allowed every cycle (full throughput).

## Timing

- Cycle N: `pN_req` high and the arbiter selects port N -> `pN_gnt` = 1 and `mem_*` valid in cycle N. A write commits at the end of N.
- Cycle N+1: `pN_rvalid` / `pN_err` pulse. Read latency is 1 cycle from grant.
- A read to address A granted in the same cycle that the other port's write to A is granted cannot occur (single grant).
- A read granted in the cycle after a write to A returns the new data.
- **Reset values:** all gnt/rvalid/err = 0, rdata = 0, `starve` = 0, state FAVOR0, `mem_*` enables = 0.
- **Reset priority and mid-operation reset:**
  - `rst` overrides everything in the cycle it is high; grants are forced to 0 during reset.
  - A read granted in the cycle before `rst` produces no rvalid after reset.
- **Simultaneous requests in FAVOR1:** port 1 is granted, port 0 is denied that cycle, and `starve` clears.

## Test plan

- **Reset:** hold `rst` 2 cycles with both req high -> no gnt. After release, state FAVOR0 and all outputs 0.
- **Port 0 round trip:** port 0 writes 0x1234 to addr 5. Next cycle, port 0 reads addr 5 -> `p0_rvalid` pulses one cycle later with `p0_rdata` = 0x1234.
- **Contention and starvation:** both ports request continuously with `STARVE_LIMIT` = 4.
  - `p0_gnt` for cycles 0-4.
  - `p1_gnt` in cycle 5.
  - `p0_gnt` resumes in cycle 6.
  - The pattern repeats every 6 cycles.
- **ROM protect:** port 1 writes addr 1 -> gnt, `mem_wr_enable` = 0, `p1_err` pulse next cycle, memory word 1 unchanged.
- **Out of range:** port 0 reads addr 256 -> `p0_err` and `p0_rvalid` pulse together with `p0_rdata` = 0.
- **Mid-operation reset:** port 1 read granted, `rst` asserted the next cycle -> `p1_rvalid` = 0 and `starve` = 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the pipeline MEM
// stage (port 0) and the debug/loader port (port 1).
//
// Port 0 has fixed priority. A starvation counter promotes port 1 after
// STARVE_LIMIT consecutive denied cycles. Requests to the ROM region (writes)
// or beyond MEM_SIZE are still granted, but they issue no memory enable and
// pulse pN_err on the following cycle. Reads return registered data with a
// one-cycle pN_rvalid strobe.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pN_req/we/addr/wdata request side; payload held until pN_gnt
//   pN_gnt              combinational accept for this cycle
//   pN_rvalid/rdata     read return, one cycle after grant
//   pN_err              one-cycle pulse after an illegal accepted request
//   mem_*               single-ported memory interface (combinational read)
module dmem_arbiter #(
  parameter int unsigned MEM_SIZE     = 256,
  parameter int unsigned ROM_SIZE     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [63:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [63:0] p0_rdata,
  output logic        p0_err,

  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [63:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [63:0] p1_rdata,
  output logic        p1_err,

  output logic [31:0] mem_addr,
  output logic [63:0] mem_wr_data,
  output logic        mem_wr_enable,
  output logic        mem_rd_enable,
  input  logic [63:0] mem_rd_data
);

  typedef enum logic [0:0] {StFavor0, StFavor1} state_e;

  localparam logic [31:0] MemLimit    = 32'(MEM_SIZE);
  localparam logic [31:0] RomLimit    = 32'(ROM_SIZE);
  localparam logic [7:0]  StarveLimit = 8'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [7:0]  starve_q, starve_d;

  logic        p0_rvalid_q, p0_rvalid_d;
  logic        p1_rvalid_q, p1_rvalid_d;
  logic        p0_err_q, p0_err_d;
  logic        p1_err_q, p1_err_d;
  logic [63:0] p0_rdata_q, p0_rdata_d;
  logic [63:0] p1_rdata_q, p1_rdata_d;

  logic        p0_legal, p1_legal;
  logic        sel_we, sel_legal, any_gnt;

  // Legality is evaluated on the request side, independent of the grant.
  always_comb begin
    p0_legal = (p0_addr < MemLimit) && !(p0_we && (p0_addr < RomLimit));
    p1_legal = (p1_addr < MemLimit) && !(p1_we && (p1_addr < RomLimit));
  end

  // Grant: a lone requester always wins; on contention the state decides.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (p0_req && p1_req) begin
        if (state_q == StFavor1) begin
          p1_gnt = 1'b1;
        end else begin
          p0_gnt = 1'b1;
        end
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end
    end
  end

  // Memory side mux; everything is zero when nothing is granted.
  always_comb begin
    mem_addr      = 32'd0;
    mem_wr_data   = 64'd0;
    sel_we        = 1'b0;
    sel_legal     = 1'b0;
    any_gnt       = p0_gnt | p1_gnt;
    if (p0_gnt) begin
      mem_addr    = p0_addr;
      mem_wr_data = p0_wdata;
      sel_we      = p0_we;
      sel_legal   = p0_legal;
    end else if (p1_gnt) begin
      mem_addr    = p1_addr;
      mem_wr_data = p1_wdata;
      sel_we      = p1_we;
      sel_legal   = p1_legal;
    end
    mem_wr_enable = any_gnt & sel_we & sel_legal;
    mem_rd_enable = any_gnt & ~sel_we & sel_legal;
  end

  // Starvation counter: counts consecutive denied port 1 cycles.
  always_comb begin
    starve_d = starve_q;
    if (!p1_req || p1_gnt) begin
      starve_d = 8'd0;
    end else if (starve_q < StarveLimit) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Arbitration FSM. The promotion uses the registered count, so FAVOR1
  // only takes effect on the cycle after the limit is observed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFavor0: begin
        if ((starve_q >= StarveLimit) && !p1_gnt) begin
          state_d = StFavor1;
        end
      end
      StFavor1: begin
        if (p1_gnt || !p1_req) begin
          state_d = StFavor0;
        end
      end
      default: state_d = StFavor0;
    endcase
  end

  // Response next-state. Illegal reads still return a strobe with zero data.
  always_comb begin
    p0_rvalid_d = p0_gnt & ~p0_we;
    p1_rvalid_d = p1_gnt & ~p1_we;
    p0_err_d    = p0_gnt & ~p0_legal;
    p1_err_d    = p1_gnt & ~p1_legal;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    if (p0_gnt && !p0_we) begin
      p0_rdata_d = p0_legal ? mem_rd_data : 64'd0;
    end
    if (p1_gnt && !p1_we) begin
      p1_rdata_d = p1_legal ? mem_rd_data : 64'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFavor0;
      starve_q    <= 8'd0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p0_rdata_q  <= 64'd0;
      p1_rdata_q  <= 64'd0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_err_q    <= p0_err_d;
      p1_err_q    <= p1_err_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  // Reset masks responses already registered from the cycle before it, so a
  // read granted just before reset never shows an rvalid.
  always_comb begin
    p0_rvalid = p0_rvalid_q & ~rst;
    p1_rvalid = p1_rvalid_q & ~rst;
    p0_err    = p0_err_q & ~rst;
    p1_err    = p1_err_q & ~rst;
    p0_rdata  = rst ? 64'd0 : p0_rdata_q;
    p1_rdata  = rst ? 64'd0 : p1_rdata_q;
  end

endmodule
